// File: rtl/div_arbiter_if.sv
// div_arbiter_if: bundles the client-side request/response bus and the
// divider-side operand/status bus of div_arbiter.
//
// Handshake: requester i raises req[i] with its operands stable on
// dividend_in/divisor_in. ack[i] pulses for one cycle once those operands
// are captured, after which req[i] may drop. done[i] pulses for one cycle
// while resp_id, q_out, r_out, ov_out, dbz_out and err_out carry its result.
// Toward the divider, div_start pulses once per operation with
// div_dividend/div_divisor stable around it; div_ready low means computing,
// high means idle or result valid.
interface div_arbiter_if #(
    parameter int N_REQ = 4
);
    // client side
    logic [N_REQ-1:0]    req;
    logic [10*N_REQ-1:0] dividend_in;
    logic [5*N_REQ-1:0]  divisor_in;
    logic [N_REQ-1:0]    ack;
    logic [N_REQ-1:0]    done;
    logic [2:0]          resp_id;
    logic [4:0]          q_out;
    logic [4:0]          r_out;
    logic                ov_out;
    logic                dbz_out;
    logic                err_out;
    logic                busy;

    // divider side
    logic                div_start;
    logic [9:0]          div_dividend;
    logic [4:0]          div_divisor;
    logic [4:0]          div_q;
    logic [4:0]          div_r;
    logic                div_ready;
    logic                div_ov;
    logic                div_dbz;

    // arbiter view
    modport slave (
        input  req, dividend_in, divisor_in,
        input  div_q, div_r, div_ready, div_ov, div_dbz,
        output ack, done, resp_id, q_out, r_out, ov_out, dbz_out, err_out, busy,
        output div_start, div_dividend, div_divisor
    );

    // clients plus divider view
    modport master (
        output req, dividend_in, divisor_in,
        output div_q, div_r, div_ready, div_ov, div_dbz,
        input  ack, done, resp_id, q_out, r_out, ov_out, dbz_out, err_out, busy,
        input  div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter/sequencer sharing one 10-by-5 divider
// between N_REQ requesters. One operation at a time:
// IDLE (arbitrate) -> ISSUE (start pulse) -> SETTLE -> WAIT (div_ready) -> DONE.
//
// Optional feature: define DIV_ARB_TIMEOUT_EN to bound WAIT to TIMEOUT
// cycles; on expiry the operation completes with err_out=1 and zeroed
// results. Without it WAIT is unbounded and err_out is constant 0.
//
// state_dbg exposes the FSM state encoding:
//   0 IDLE, 1 ISSUE, 2 SETTLE, 3 WAIT, 4 DONE.
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,        // asynchronous, active low
    div_arbiter_if.slave bus,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nx;

    // arbitration
    logic [2:0]       ptr;
    logic [2:0]       grant_id;
    logic [2:0]       pick_id;
    logic             pick_valid;
    logic [3:0]       cand;
    logic [7:0]       req_pad;

    // sequencing strobes
    logic             grant_go;
    logic             start_go;
    logic             take_result;
    logic             take_abort;
    logic             issued;
    logic             timed_out;

    // registered outputs
    logic [N_REQ-1:0] ack_r;
    logic [N_REQ-1:0] done_r;
    logic             start_r;
    logic [9:0]       dividend_r;
    logic [4:0]       divisor_r;
    logic [2:0]       resp_id_r;
    logic [4:0]       q_r;
    logic [4:0]       r_r;
    logic             ov_r;
    logic             dbz_r;

    // Padding req to 8 bits lets a 3-bit index address it for any N_REQ.
    assign req_pad = 8'(bus.req);

    // Pick the first requester at or after ptr, wrapping; scanning from the
    // far end lets the closest one overwrite the others.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = 3'd0;
        cand       = 4'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (req_pad[cand[2:0]]) begin
                pick_valid = 1'b1;
                pick_id    = cand[2:0];
            end
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_r;

    // WAIT-cycle counter: held at zero outside WAIT, so it starts from zero
    // on every entry to WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // The abort fires in the TIMEOUT-th WAIT cycle.
    assign timed_out = ((wait_cnt + 8'd1) == 8'(TIMEOUT));

    // Error flag: set by an abort, cleared by a real result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (take_abort) begin
            err_r <= 1'b1;
        end else if (take_result) begin
            err_r <= 1'b0;
        end
    end

    assign bus.err_out = err_r;
`else
    // TIMEOUT is non-negative, so this is constant low: WAIT has no bound.
    assign timed_out   = (TIMEOUT < 0);
    assign bus.err_out = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and single-cycle strobes for the datapath.
    // ISSUE spends two cycles: the first registers div_start, the second
    // presents it to the divider, so the pulse is a clean flop output.
    always_comb begin
        state_nx    = state;
        grant_go    = 1'b0;
        start_go    = 1'b0;
        take_result = 1'b0;
        take_abort  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_go = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!issued) begin
                    start_go = 1'b1;
                end else begin
                    state_nx = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.div_ready) begin
                    take_result = 1'b1;
                    state_nx    = S_DONE;
                end else if (timed_out) begin
                    take_abort  = 1'b1;
                    state_nx    = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: grant capture, start pulse, result capture and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= 3'd0;
            grant_id   <= 3'd0;
            issued     <= 1'b0;
            ack_r      <= '0;
            done_r     <= '0;
            start_r    <= 1'b0;
            dividend_r <= 10'd0;
            divisor_r  <= 5'd0;
            resp_id_r  <= 3'd0;
            q_r        <= 5'd0;
            r_r        <= 5'd0;
            ov_r       <= 1'b0;
            dbz_r      <= 1'b0;
        end else begin
            ack_r   <= '0;
            done_r  <= '0;
            start_r <= 1'b0;

            if (grant_go) begin
                grant_id   <= pick_id;
                issued     <= 1'b0;
                ack_r      <= N_REQ'(1) << pick_id;
                dividend_r <= bus.dividend_in[int'(pick_id)*10 +: 10];
                divisor_r  <= bus.divisor_in[int'(pick_id)*5 +: 5];
                ptr        <= (pick_id == 3'(N_REQ - 1)) ? 3'd0 : pick_id + 3'd1;
            end

            if (start_go) begin
                start_r <= 1'b1;
                issued  <= 1'b1;
            end

            if (take_result) begin
                q_r       <= bus.div_q;
                r_r       <= bus.div_r;
                ov_r      <= bus.div_ov;
                dbz_r     <= bus.div_dbz;
                resp_id_r <= grant_id;
                done_r    <= N_REQ'(1) << grant_id;
            end

            if (take_abort) begin
                q_r       <= 5'd0;
                r_r       <= 5'd0;
                ov_r      <= 1'b0;
                dbz_r     <= 1'b0;
                resp_id_r <= grant_id;
                done_r    <= N_REQ'(1) << grant_id;
            end
        end
    end

    assign bus.ack          = ack_r;
    assign bus.done         = done_r;
    assign bus.div_start    = start_r;
    assign bus.div_dividend = dividend_r;
    assign bus.div_divisor  = divisor_r;
    assign bus.resp_id      = resp_id_r;
    assign bus.q_out        = q_r;
    assign bus.r_out        = r_r;
    assign bus.ov_out       = ov_r;
    assign bus.dbz_out      = dbz_r;
    assign bus.busy         = (state != S_IDLE);
    assign state_dbg        = state;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a behavioural divider
// stub. Expected results are hand-computed constants queued in exp_q.
module tb_div_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 20;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;

    logic       clk;
    logic       rst;
    logic [2:0] state_dbg;

    div_arbiter_if #(.N_REQ(N_REQ)) bus ();

    div_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- divider stub ----------------
    logic       stub_ready = 1'b1;
    logic [4:0] stub_q     = 5'd0;
    logic [4:0] stub_r     = 5'd0;
    logic       stub_ov    = 1'b0;
    logic       stub_dbz   = 1'b0;
    logic [9:0] stub_a     = 10'd0;
    logic [4:0] stub_b     = 5'd0;
    int         stub_cnt   = 0;
    int         stub_lat   = 3;
    bit         stub_stall = 1'b0;

    assign bus.div_ready = stub_ready;
    assign bus.div_q     = stub_q;
    assign bus.div_r     = stub_r;
    assign bus.div_ov    = stub_ov;
    assign bus.div_dbz   = stub_dbz;

    // Stub: ready drops after a start, returns stub_lat+1 edges later unless stalled.
    always @(posedge clk) begin
        if (bus.div_start) begin
            stub_a     <= bus.div_dividend;
            stub_b     <= bus.div_divisor;
            stub_cnt   <= stub_lat;
            stub_ready <= 1'b0;
        end else if (!stub_ready && !stub_stall) begin
            if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
            end else begin
                stub_ready <= 1'b1;
                if (stub_b == 5'd0) begin
                    stub_q <= 5'd0; stub_r <= 5'd0; stub_ov <= 1'b0; stub_dbz <= 1'b1;
                end else if ((stub_a / 10'(stub_b)) > 10'd31) begin
                    stub_q <= 5'd0; stub_r <= 5'd0; stub_ov <= 1'b1; stub_dbz <= 1'b0;
                end else begin
                    stub_q   <= 5'(stub_a / 10'(stub_b));
                    stub_r   <= 5'(stub_a % 10'(stub_b));
                    stub_ov  <= 1'b0;
                    stub_dbz <= 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [14:0]      exp_q[$];   // {id[2:0], q[4:0], r[4:0], ov, dbz}
    int               vectors     = 0;
    int               miscompares = 0;
    int               n_ack       = 0;
    int               n_done      = 0;
    int               n_start     = 0;
    logic [N_REQ-1:0] last_ack    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input int q, input int r, input bit ov, input bit dbz);
        exp_q.push_back({3'(id), 5'(q), 5'(r), ov, dbz});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        if (bus.ack != '0) begin
            n_ack++;
            last_ack = bus.ack;
            chk("ack_onehot", 32'($countones(bus.ack)), 1);
        end
        if (bus.done != '0) begin
            n_done++;
            chk("done_onehot", 32'($countones(bus.done)), 1);
        end
        if (bus.div_start) n_start++;
    endtask

    task automatic set_ops(input int id, input int a, input int b);
        bus.dividend_in[id*10 +: 10] = 10'(a);
        bus.divisor_in[id*5 +: 5]    = 5'(b);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_dbg !== s && n < budget) begin
            step();
            n++;
        end
        chk("wait_state_bound", 32'(state_dbg === s), 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        step();
        while (bus.done === '0 && n < budget) begin
            step();
            n++;
        end
        chk("done_bound", 32'(bus.done !== '0), 1);
    endtask

    task automatic check_result(input string tag);
        logic [14:0]      e;
        logic [N_REQ-1:0] exp_done;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: no expected entry queued", tag);
        end else begin
            e        = exp_q.pop_front();
            exp_done = N_REQ'(1) << e[14:12];
            chk({tag, "_done"},    32'(bus.done),    32'(exp_done));
            chk({tag, "_resp_id"}, 32'(bus.resp_id), 32'(e[14:12]));
            chk({tag, "_q"},       32'(bus.q_out),   32'(e[11:7]));
            chk({tag, "_r"},       32'(bus.r_out),   32'(e[6:2]));
            chk({tag, "_ov"},      32'(bus.ov_out),  32'(e[1]));
            chk({tag, "_dbz"},     32'(bus.dbz_out), 32'(e[0]));
            chk({tag, "_err"},     32'(bus.err_out), 0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a0;
        int s0;
        int d0;
        int n;

        rst             = 1'b0;
        bus.req         = '0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        repeat (3) step();

        // reset values
        chk("rst_ack",       32'(bus.ack),          0);
        chk("rst_done",      32'(bus.done),         0);
        chk("rst_start",     32'(bus.div_start),    0);
        chk("rst_dividend",  32'(bus.div_dividend), 0);
        chk("rst_divisor",   32'(bus.div_divisor),  0);
        chk("rst_resp_id",   32'(bus.resp_id),      0);
        chk("rst_q",         32'(bus.q_out),        0);
        chk("rst_r",         32'(bus.r_out),        0);
        chk("rst_ov",        32'(bus.ov_out),       0);
        chk("rst_dbz",       32'(bus.dbz_out),      0);
        chk("rst_err",       32'(bus.err_out),      0);
        chk("rst_busy",      32'(bus.busy),         0);
        chk("rst_state",     32'(state_dbg),        32'(ST_IDLE));
        rst = 1'b1;
        step();

        // single request 100/7 -> 14 r 2, cycle-by-cycle latency
        s0 = n_start;
        a0 = n_ack;
        set_ops(0, 100, 7);
        bus.req = 4'b0001;
        step();
        chk("t1_ack",      32'(bus.ack),          32'(4'b0001));
        chk("t1_state_is", 32'(state_dbg),        32'(ST_ISSUE));
        chk("t1_start_lo", 32'(bus.div_start),    0);
        chk("t1_dividend", 32'(bus.div_dividend), 100);
        chk("t1_divisor",  32'(bus.div_divisor),  7);
        chk("t1_busy",     32'(bus.busy),         1);
        bus.req = '0;
        step();
        chk("t1_start_hi", 32'(bus.div_start),    1);
        chk("t1_ack_lo",   32'(bus.ack),          0);
        step();
        chk("t1_start_end", 32'(bus.div_start),   0);
        chk("t1_settle",   32'(state_dbg),        32'(ST_SETTLE));
        step();
        chk("t1_wait",     32'(state_dbg),        32'(ST_WAIT));
        chk("t1_hold_dvd", 32'(bus.div_dividend), 100);
        push_exp(0, 14, 2, 1'b0, 1'b0);
        wait_done(60);
        check_result("t1");
        chk("t1_one_start", 32'(n_start - s0), 1);
        chk("t1_one_ack",   32'(n_ack - a0),   1);
        step();
        chk("t1_done_lo",  32'(bus.done), 0);
        chk("t1_idle",     32'(bus.busy), 0);

        // all four held from ptr=0 -> grants 0,1,2,3,0
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        set_ops(0, 100, 7);
        set_ops(1, 200, 9);
        set_ops(2, 50, 6);
        set_ops(3, 31, 4);
        push_exp(0, 14, 2, 1'b0, 1'b0);
        push_exp(1, 22, 2, 1'b0, 1'b0);
        push_exp(2, 8, 2, 1'b0, 1'b0);
        push_exp(3, 7, 3, 1'b0, 1'b0);
        push_exp(0, 14, 2, 1'b0, 1'b0);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            a0 = n_ack;
            s0 = n_start;
            wait_done(60);
            if (i == 4) bus.req = '0;
            chk("t2_ack_id",   32'(last_ack), 32'(bus.done));
            chk("t2_one_ack",  32'(n_ack - a0), 1);
            chk("t2_one_start", 32'(n_start - s0), 1);
            check_result("t2");
        end
        repeat (3) step();
        chk("t2_idle", 32'(bus.busy), 0);

        // requester 1: 1000/3 overflows; ptr moves to 2
        set_ops(1, 1000, 3);
        bus.req = 4'b0010;
        push_exp(1, 0, 0, 1'b1, 1'b0);
        wait_done(60);
        bus.req = '0;
        check_result("t4_ov");

        // ptr=2 with req=0011 -> requester 0 wins, not 1
        set_ops(0, 77, 5);
        bus.req = 4'b0011;
        push_exp(0, 15, 2, 1'b0, 1'b0);
        wait_done(60);
        bus.req = '0;
        check_result("t3_ptr");

        // requester 2: divide by zero
        set_ops(2, 123, 0);
        bus.req = 4'b0100;
        push_exp(2, 0, 0, 1'b0, 1'b1);
        wait_done(60);
        bus.req = '0;
        check_result("t4_dbz");
        step();

        // reset while in WAIT aborts with no done
        stub_stall = 1'b1;
        set_ops(3, 60, 8);
        bus.req = 4'b1000;
        wait_state(ST_WAIT, 40);
        step();
        d0 = n_done;
        rst = 1'b0;
        #1;
        chk("t5_state",    32'(state_dbg),        32'(ST_IDLE));
        chk("t5_busy",     32'(bus.busy),         0);
        chk("t5_dividend", 32'(bus.div_dividend), 0);
        chk("t5_divisor",  32'(bus.div_divisor),  0);
        chk("t5_resp_id",  32'(bus.resp_id),      0);
        chk("t5_dbz",      32'(bus.dbz_out),      0);
        chk("t5_done",     32'(bus.done),         0);
        repeat (2) step();
        chk("t5_no_done",  32'(n_done - d0),      0);
        rst = 1'b1;
        stub_stall = 1'b0;
        push_exp(3, 7, 4, 1'b0, 1'b0);
        wait_done(100);
        bus.req = '0;
        check_result("t5_after");
        step();

        // divider never ready
        stub_stall = 1'b1;
        set_ops(0, 9, 3);
        bus.req = 4'b0001;
        wait_state(ST_WAIT, 40);
        bus.req = '0;
`ifdef DIV_ARB_TIMEOUT_EN
        n = 0;
        while (state_dbg === ST_WAIT && n < 100) begin
            n++;
            step();
        end
        chk("t6_wait_cycles", 32'(n),            32'(TIMEOUT));
        chk("t6_done",        32'(bus.done),     32'(4'b0001));
        chk("t6_err",         32'(bus.err_out),  1);
        chk("t6_q",           32'(bus.q_out),    0);
        chk("t6_r",           32'(bus.r_out),    0);
        chk("t6_ov",          32'(bus.ov_out),   0);
        chk("t6_dbz",         32'(bus.dbz_out),  0);
        chk("t6_resp_id",     32'(bus.resp_id),  0);
        stub_stall = 1'b0;
        repeat (10) step();
`else
        d0 = n_done;
        n  = 0;
        repeat (300) step();
        chk("t6_still_wait", 32'(state_dbg),    32'(ST_WAIT));
        chk("t6_busy",       32'(bus.busy),     1);
        chk("t6_no_done",    32'(n_done - d0),  0);
        stub_stall = 1'b0;
        push_exp(0, 3, 0, 1'b0, 1'b0);
        wait_done(60);
        check_result("t6_release");
        step();
`endif
        chk("end_idle", 32'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
